// File: rtl/btn_pkg.sv
// Shared types and default timing constants for the push-button conditioner.
package btn_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARMED  = 2'd1,
        REPEAT = 2'd2
    } btn_state_t;

    localparam int DEF_DEBOUNCE_CYCLES = 1000000;
    localparam int DEF_HOLD_CYCLES     = 50000000;
    localparam int DEF_REPEAT_CYCLES   = 10000000;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/btn_channel.sv
// One button channel: 2-flop synchronizer, debounce counter and press FSM.
// Auto-repeat logic is present only when BTN_AUTOREPEAT_EN is defined.
module btn_channel
    import btn_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int HOLD_CYCLES     = DEF_HOLD_CYCLES,
    parameter int REPEAT_CYCLES   = DEF_REPEAT_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic level,
    output logic blip,
    output logic level_nxt
);

    localparam int CW = $clog2(max3(DEBOUNCE_CYCLES, HOLD_CYCLES, REPEAT_CYCLES)) + 1;

    logic          sync1_r, sync2_r;
    logic [CW-1:0] cnt_r, cnt_nxt_s;
    logic          level_r, level_nxt_s;
    logic          blip_r, blip_nxt_s;
    logic          differ_s, fire_s, rise_s, fall_s;
    btn_state_t    state_r, state_nxt_s;
`ifdef BTN_AUTOREPEAT_EN
    logic [CW-1:0] hold_r, hold_nxt_s;
    logic [CW-1:0] rep_r, rep_nxt_s;
`endif

    // Debounce: level toggles once the synchronized input has differed for DEBOUNCE_CYCLES samples.
    always_comb begin
        differ_s    = sync2_r ^ level_r;
        fire_s      = differ_s && (cnt_r == CW'(DEBOUNCE_CYCLES - 1));
        rise_s      = fire_s && !level_r;
        fall_s      = fire_s && level_r;
        level_nxt_s = fire_s ? ~level_r : level_r;
        if (!differ_s || fire_s) begin
            cnt_nxt_s = {CW{1'b0}};
        end else if (cnt_r < CW'(DEBOUNCE_CYCLES - 1)) begin
            cnt_nxt_s = cnt_r + CW'(1);
        end else begin
            cnt_nxt_s = cnt_r;
        end
    end

    // Press FSM; a debounced release always wins over a pending repeat blip.
    always_comb begin
        state_nxt_s = state_r;
        blip_nxt_s  = 1'b0;
`ifdef BTN_AUTOREPEAT_EN
        hold_nxt_s  = hold_r;
        rep_nxt_s   = rep_r;
`endif
        case (state_r)
            IDLE: begin
                if (rise_s) begin
                    state_nxt_s = ARMED;
                    blip_nxt_s  = 1'b1;
`ifdef BTN_AUTOREPEAT_EN
                    hold_nxt_s  = {CW{1'b0}};
`endif
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            ARMED: begin
                if (fall_s) begin
                    state_nxt_s = IDLE;
`ifdef BTN_AUTOREPEAT_EN
                end else if (hold_r == CW'(HOLD_CYCLES - 1)) begin
                    state_nxt_s = REPEAT;
                    blip_nxt_s  = 1'b1;
                    rep_nxt_s   = {CW{1'b0}};
                end else begin
                    hold_nxt_s  = hold_r + CW'(1);
`else
                end else begin
                    state_nxt_s = ARMED;
`endif
                end
            end
`ifdef BTN_AUTOREPEAT_EN
            REPEAT: begin
                if (fall_s) begin
                    state_nxt_s = IDLE;
                end else if (rep_r >= CW'(REPEAT_CYCLES - 1)) begin
                    blip_nxt_s  = 1'b1;
                    rep_nxt_s   = {CW{1'b0}};
                end else begin
                    rep_nxt_s   = rep_r + CW'(1);
                end
            end
`endif
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
            cnt_r   <= {CW{1'b0}};
            level_r <= 1'b0;
            blip_r  <= 1'b0;
            state_r <= IDLE;
`ifdef BTN_AUTOREPEAT_EN
            hold_r  <= {CW{1'b0}};
            rep_r   <= {CW{1'b0}};
`endif
        end else begin
            sync1_r <= raw;
            sync2_r <= sync1_r;
            cnt_r   <= cnt_nxt_s;
            level_r <= level_nxt_s;
            blip_r  <= blip_nxt_s;
            state_r <= state_nxt_s;
`ifdef BTN_AUTOREPEAT_EN
            hold_r  <= hold_nxt_s;
            rep_r   <= rep_nxt_s;
`endif
        end
    end

    assign level     = level_r;
    assign blip      = blip_r;
    assign level_nxt = reset ? 1'b0 : level_nxt_s;

endmodule

// File: rtl/btn_conditioner.sv
// Debounce and press-pulse generation for NUM_BTN push buttons.
// Define BTN_AUTOREPEAT_EN to enable hold-to-repeat blips.
module btn_conditioner
    import btn_pkg::*;
#(
    parameter int NUM_BTN         = 3,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int HOLD_CYCLES     = DEF_HOLD_CYCLES,
    parameter int REPEAT_CYCLES   = DEF_REPEAT_CYCLES
) (
    input  logic               Clk100M,
    input  logic               reset,
    input  logic [NUM_BTN-1:0] btn_raw,
    output logic [NUM_BTN-1:0] level,
    output logic [NUM_BTN-1:0] blip,
    output logic               any_held
);

    logic [NUM_BTN-1:0] level_nxt_s;
    logic               any_held_r;

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_ch
        btn_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .HOLD_CYCLES     (HOLD_CYCLES),
            .REPEAT_CYCLES   (REPEAT_CYCLES)
        ) u_ch (
            .clk       (Clk100M),
            .reset     (reset),
            .raw       (btn_raw[i]),
            .level     (level[i]),
            .blip      (blip[i]),
            .level_nxt (level_nxt_s[i])
        );
    end

    // Registered from next-state levels so any_held lines up with level.
    always_ff @(posedge Clk100M) begin
        if (reset) begin
            any_held_r <= 1'b0;
        end else begin
            any_held_r <= |level_nxt_s;
        end
    end

    assign any_held = any_held_r;

endmodule

// File: tb/tb_btn_conditioner.sv
// Directed self-checking bench for btn_conditioner (DEBOUNCE=4, HOLD=10, REPEAT=3).
module tb_btn_conditioner;

    logic       Clk100M = 1'b0;
    logic       reset;
    logic [2:0] btn_raw;
    logic [2:0] level;
    logic [2:0] blip;
    logic       any_held;

    int checks = 0;
    int errors = 0;

    btn_conditioner #(
        .NUM_BTN         (3),
        .DEBOUNCE_CYCLES (4),
        .HOLD_CYCLES     (10),
        .REPEAT_CYCLES   (3)
    ) dut (
        .Clk100M  (Clk100M),
        .reset    (reset),
        .btn_raw  (btn_raw),
        .level    (level),
        .blip     (blip),
        .any_held (any_held)
    );

    always #5 Clk100M = ~Clk100M;

    task automatic tick();
        @(posedge Clk100M);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic repeat_blip(input int e);
`ifdef BTN_AUTOREPEAT_EN
        return (e == 6) || (e >= 16 && e <= 35 && ((e - 16) % 3) == 0);
`else
        return (e == 6);
`endif
    endfunction

    initial begin
        btn_raw = 3'b000;
        reset   = 1'b1;
        repeat (3) tick();
        check("rst_level", 32'(level), 32'd0);
        check("rst_blip", 32'(blip), 32'd0);
        check("rst_any", 32'(any_held), 32'd0);
        reset = 1'b0;
        tick();

        // Clean press on channel 0
        btn_raw[0] = 1'b1;
        for (int e = 1; e <= 10; e++) begin
            tick();
            check("press_level", 32'(level[0]), 32'(e >= 6));
            check("press_blip", 32'(blip[0]), 32'(e == 6));
            check("press_any", 32'(any_held), 32'(e >= 6));
        end
        // Release: no blip, level falls 6 edges later
        btn_raw[0] = 1'b0;
        for (int e = 1; e <= 8; e++) begin
            tick();
            check("rel_level", 32'(level[0]), 32'(e < 6));
            check("rel_blip", 32'(blip[0]), 32'd0);
        end

        // Bounce on channel 1
        for (int e = 1; e <= 12; e++) begin
            btn_raw[1] = (e <= 4) ? ((e % 2) == 1) : 1'b0;
            tick();
            check("bounce_level", 32'(level), 32'd0);
            check("bounce_blip", 32'(blip), 32'd0);
        end

        // Simultaneous press on channels 0 and 2
        btn_raw = 3'b101;
        for (int e = 1; e <= 8; e++) begin
            tick();
            check("simul_blip", 32'(blip), (e == 6) ? 32'h5 : 32'h0);
            check("simul_level", 32'(level), (e >= 6) ? 32'h5 : 32'h0);
            check("simul_any", 32'(any_held), 32'(e >= 6));
        end

        // Reset while held, then held through release => new press
        reset = 1'b1;
        tick();
        check("rsthold_level", 32'(level), 32'd0);
        check("rsthold_blip", 32'(blip), 32'd0);
        check("rsthold_any", 32'(any_held), 32'd0);
        reset = 1'b0;
        for (int e = 1; e <= 8; e++) begin
            tick();
            check("repress_blip", 32'(blip), (e == 6) ? 32'h5 : 32'h0);
            check("repress_any", 32'(any_held), 32'(e >= 6));
        end
        btn_raw = 3'b000;
        repeat (10) tick();
        check("idle_level", 32'(level), 32'd0);

        // Reset mid-debounce on channel 0
        btn_raw[0] = 1'b1;
        tick();
        tick();
        reset = 1'b1;
        tick();
        check("rstmid_level", 32'(level), 32'd0);
        check("rstmid_blip", 32'(blip), 32'd0);
        reset = 1'b0;
        for (int e = 1; e <= 8; e++) begin
            tick();
            check("rstmid_pblip", 32'(blip[0]), 32'(e == 6));
            check("rstmid_plevel", 32'(level[0]), 32'(e >= 6));
        end
        btn_raw = 3'b000;
        repeat (10) tick();

        // Hold for 30 cycles: auto-repeat behaviour depends on build
        for (int e = 1; e <= 45; e++) begin
            btn_raw[0] = (e <= 30);
            tick();
            check("hold_blip", 32'(blip[0]), 32'(repeat_blip(e)));
            check("hold_level", 32'(level[0]), 32'(e >= 6 && e < 36));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
